// File: rtl/l2c_req_arbiter.sv
// Two-port round-robin request arbiter in front of the L2 cache with in-order answer routing.
// Optional per-port grant and stall counters are enabled with LEN5_L2ARB_PERF_EN.
module l2c_req_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int LINE_W    = 512,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              c0_req_valid_i,
    output logic              c0_req_rdy_o,
    input  logic              c0_req_we_i,
    input  logic [ADDR_W-1:0] c0_req_addr_i,
    input  logic [LINE_W-1:0] c0_req_data_i,
    output logic              c0_ans_valid_o,
    input  logic              c0_ans_rdy_i,
    input  logic              c1_req_valid_i,
    output logic              c1_req_rdy_o,
    input  logic              c1_req_we_i,
    input  logic [ADDR_W-1:0] c1_req_addr_i,
    input  logic [LINE_W-1:0] c1_req_data_i,
    output logic              c1_ans_valid_o,
    input  logic              c1_ans_rdy_i,
    output logic              l2_req_valid_o,
    input  logic              l2_req_rdy_i,
    output logic              l2_req_we_o,
    output logic [ADDR_W-1:0] l2_req_addr_o,
    output logic [LINE_W-1:0] l2_req_data_o,
    input  logic              l2_ans_valid_i,
    output logic              l2_ans_rdy_o,
    input  logic [ADDR_W-1:0] l2_ans_addr_i,
    input  logic [LINE_W-1:0] l2_ans_data_i,
    output logic [ADDR_W-1:0] ans_addr_o,
    output logic [LINE_W-1:0] ans_data_o,
    output logic              err_o
`ifdef LEN5_L2ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int IDX_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = IDX_W + 1;

    logic              r_slotValid;
    logic              r_slotWe;
    logic [ADDR_W-1:0] r_slotAddr;
    logic [LINE_W-1:0] r_slotData;
    logic              r_rrPtr;
    logic              r_err;
    logic [CNT_W-1:0]  r_pushCnt;
    logic [CNT_W-1:0]  r_popCnt;
    logic [MAX_OUTST-1:0] r_ownerMem;

    logic w_empty;
    logic w_full;
    logic w_head;
    logic w_gntEn;
    logic w_gnt0;
    logic w_gnt1;
    logic w_grant;
    logic w_ansActive;
    logic w_pop;
    logic w_spurious;

    // The extra wrap bit distinguishes a full FIFO from an empty one when the indices match.
    assign w_empty = (r_pushCnt == r_popCnt);
    assign w_full  = (r_pushCnt[IDX_W-1:0] == r_popCnt[IDX_W-1:0]) &&
                     (r_pushCnt[IDX_W] != r_popCnt[IDX_W]);
    assign w_head  = r_ownerMem[r_popCnt[IDX_W-1:0]];

    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_gntEn = rst_n_i && (!r_slotValid || l2_req_rdy_i) && !w_full && !flush_i;
        if (w_gntEn) begin
            if (c0_req_valid_i && c1_req_valid_i) begin
                w_gnt0 = !r_rrPtr;
                w_gnt1 = r_rrPtr;
            end else begin
                w_gnt0 = c0_req_valid_i;
                w_gnt1 = c1_req_valid_i;
            end
        end
    end

    assign w_grant      = w_gnt0 || w_gnt1;
    assign c0_req_rdy_o = w_gnt0;
    assign c1_req_rdy_o = w_gnt1;

    // During flush answers are swallowed without being routed or flagged.
    assign w_ansActive    = rst_n_i && !flush_i;
    assign c0_ans_valid_o = w_ansActive && l2_ans_valid_i && !w_empty && !w_head;
    assign c1_ans_valid_o = w_ansActive && l2_ans_valid_i && !w_empty && w_head;
    assign l2_ans_rdy_o   = rst_n_i && (flush_i || w_empty ||
                                        (w_head ? c1_ans_rdy_i : c0_ans_rdy_i));
    assign w_pop          = w_ansActive && l2_ans_valid_i && l2_ans_rdy_o && !w_empty;
    assign w_spurious     = w_ansActive && l2_ans_valid_i && w_empty;

    assign ans_addr_o = rst_n_i ? l2_ans_addr_i : '0;
    assign ans_data_o = rst_n_i ? l2_ans_data_i : '0;

    assign l2_req_valid_o = r_slotValid;
    assign l2_req_we_o    = r_slotWe;
    assign l2_req_addr_o  = r_slotAddr;
    assign l2_req_data_o  = r_slotData;
    assign err_o          = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_slotValid <= 1'b0;
            r_slotWe    <= 1'b0;
            r_slotAddr  <= '0;
            r_slotData  <= '0;
            r_rrPtr     <= 1'b0;
            r_err       <= 1'b0;
            r_pushCnt   <= '0;
            r_popCnt    <= '0;
        end else if (flush_i) begin
            r_slotValid <= 1'b0;
            r_pushCnt   <= '0;
            r_popCnt    <= '0;
        end else begin
            if (w_grant) begin
                r_slotValid <= 1'b1;
                r_slotWe    <= w_gnt1 ? c1_req_we_i   : c0_req_we_i;
                r_slotAddr  <= w_gnt1 ? c1_req_addr_i : c0_req_addr_i;
                r_slotData  <= w_gnt1 ? c1_req_data_i : c0_req_data_i;
                r_pushCnt   <= r_pushCnt + CNT_W'(1);
                r_rrPtr     <= !w_gnt1;
            end else if (l2_req_rdy_i) begin
                r_slotValid <= 1'b0;
            end
            if (w_pop) begin
                r_popCnt <= r_popCnt + CNT_W'(1);
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // Owner storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_ownerMem[r_pushCnt[IDX_W-1:0]] <= w_gnt1;
        end
    end

`ifdef LEN5_L2ARB_PERF_EN
    logic [31:0] r_perfGrant0;
    logic [31:0] r_perfGrant1;
    logic [31:0] r_perfStall;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_perfGrant0 <= '0;
            r_perfGrant1 <= '0;
            r_perfStall  <= '0;
        end else begin
            if (w_gnt0 && (r_perfGrant0 != 32'hFFFF_FFFF)) begin
                r_perfGrant0 <= r_perfGrant0 + 32'd1;
            end
            if (w_gnt1 && (r_perfGrant1 != 32'hFFFF_FFFF)) begin
                r_perfGrant1 <= r_perfGrant1 + 32'd1;
            end
            if ((c0_req_valid_i || c1_req_valid_i) && w_full &&
                (r_perfStall != 32'hFFFF_FFFF)) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign perf_grant0_o = r_perfGrant0;
    assign perf_grant1_o = r_perfGrant1;
    assign perf_stall_o  = r_perfStall;
`endif

endmodule
